// File: rtl/audio_agc_pwm_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// audio_agc_pwm_if : sample-in / audio-out signal bundle for audio_agc_pwm. Rev 1.0
// ----------------------------------------------------------------------------
interface audio_agc_pwm_if;
  logic [15:0] in_sample;
  logic        in_tick;
  logic        agc_en;
  logic [7:0]  gain_manual;
  logic [15:0] audio_out;
  logic        audio_tick;
  logic [7:0]  gain_out;
  logic        overrun;
  logic        pwm_out;

  modport master (
    output in_sample, in_tick, agc_en, gain_manual,
    input  audio_out, audio_tick, gain_out, overrun, pwm_out
  );

  modport slave (
    input  in_sample, in_tick, agc_en, gain_manual,
    output audio_out, audio_tick, gain_out, overrun, pwm_out
  );
endinterface
`default_nettype wire

// File: rtl/audio_agc_pwm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// audio_agc_pwm : DC block, AGC shift-add gain, sat16 and double-buffered PWM. Rev 1.0
// ----------------------------------------------------------------------------
module audio_agc_pwm #(
  parameter int unsigned DCB_SHIFT     = 8,
  parameter int unsigned PWM_BITS      = 10,
  parameter logic [15:0] AGC_TARGET    = 16'h4000,
  parameter logic [7:0]  ATTACK_STEP   = 8'd4,
  parameter logic [15:0] DECAY_SAMPLES = 16'd1024,
  parameter logic [7:0]  GAIN_INIT     = 8'h10,
  parameter logic [7:0]  GAIN_MIN      = 8'h01,
  parameter logic [7:0]  GAIN_MAX      = 8'hFF
) (
  input  logic           clk,
  input  logic           RST,
  audio_agc_pwm_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_DCB, S_MUL, S_OUT} state_t;

  localparam logic [PWM_BITS-1:0] c_duty_mid = {1'b1, {(PWM_BITS-1){1'b0}}};

  function automatic logic signed [15:0] sat16(input logic signed [23:0] v);
    if (v > 24'sd32767)
      return 16'sh7FFF;
    else if (v < -24'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

  state_t               state_q;
  logic [15:0]          sample_q;
  logic [7:0]           mgain_q;
  logic signed [16:0]   xprev_q;
  logic signed [19:0]   y_q;
  logic signed [23:0]   acc_q;
  logic signed [23:0]   mcand_q;
  logic [7:0]           mplier_q;
  logic [2:0]           bit_q;
  logic signed [15:0]   audio_q;
  logic                 tick_q;
  logic [7:0]           gain_q;
  logic [15:0]          dcnt_q;
  logic                 ovr_q;
  logic                 pwm_q;
  logic [PWM_BITS-1:0]  pcnt_q;
  logic [PWM_BITS-1:0]  dact_q;
  logic [PWM_BITS-1:0]  dpend_q;

  logic signed [16:0]   x_w;
  logic signed [16:0]   diff_w;
  logic signed [19:0]   diff20_w;
  logic signed [19:0]   ysh_w;
  logic signed [19:0]   y_d;
  logic signed [23:0]   y24_w;
  logic signed [15:0]   a_w;
  logic signed [23:0]   psh_w;
  logic signed [15:0]   audio_w;
  logic [15:0]          mag_w;
  logic [8:0]           gain_floor_w;
  logic [7:0]           gain_dn_w;
  logic [7:0]           gain_up_w;
  logic [7:0]           gain_d;
  logic [15:0]          dcnt_d;
  logic [PWM_BITS-1:0]  dpend_d;

  // DC blocker: each term is kept signed so the pole shift stays arithmetic.
  assign x_w      = {1'b0, sample_q};
  assign diff_w   = x_w - xprev_q;
  assign diff20_w = diff_w;
  assign ysh_w    = y_q >>> DCB_SHIFT;
  assign y_d      = y_q + diff20_w - ysh_w;
  assign y24_w    = y_d;
  assign a_w      = sat16(y24_w);

  assign psh_w    = acc_q >>> 4;
  assign audio_w  = sat16(psh_w);
  assign mag_w    = audio_w[15] ? ((audio_w == 16'sh8000) ? 16'h7FFF : 16'(-audio_w))
                                : audio_w;

  assign gain_floor_w = {1'b0, GAIN_MIN} + {1'b0, ATTACK_STEP};
  assign gain_dn_w    = ({1'b0, gain_q} >= gain_floor_w) ? (gain_q - ATTACK_STEP) : GAIN_MIN;
  assign gain_up_w    = (gain_q >= GAIN_MAX) ? GAIN_MAX : (gain_q + 8'd1);

  always_comb begin
    gain_d = gain_q;
    dcnt_d = dcnt_q;
    if (!bus.agc_en) begin
      gain_d = bus.gain_manual;
      dcnt_d = '0;
    end else if (state_q == S_OUT) begin
      if (mag_w > AGC_TARGET) begin
        gain_d = gain_dn_w;
        dcnt_d = '0;
      end else if (mag_w < (AGC_TARGET >> 1)) begin
        if (dcnt_q + 16'd1 == DECAY_SAMPLES) begin
          gain_d = gain_up_w;
          dcnt_d = '0;
        end else begin
          dcnt_d = dcnt_q + 16'd1;
        end
      end else begin
        dcnt_d = '0;
      end
    end
  end

  // Offset-binary duty from the finished sample; otherwise hold the buffer.
  assign dpend_d = (state_q == S_OUT) ? {~audio_w[15], audio_w[14:16-PWM_BITS]} : dpend_q;

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q  <= S_IDLE;
      sample_q <= '0;
      mgain_q  <= '0;
      xprev_q  <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      bit_q    <= '0;
      audio_q  <= '0;
      tick_q   <= 1'b0;
      gain_q   <= GAIN_INIT;
      dcnt_q   <= '0;
      ovr_q    <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      gain_q <= gain_d;
      dcnt_q <= dcnt_d;
      if (bus.in_tick && (state_q != S_IDLE))
        ovr_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (bus.in_tick) begin
            sample_q <= bus.in_sample;
            mgain_q  <= bus.agc_en ? gain_q : bus.gain_manual;
            state_q  <= S_DCB;
          end
        end
        S_DCB: begin
          xprev_q  <= x_w;
          y_q      <= y_d;
          mcand_q  <= {{8{a_w[15]}}, a_w};
          acc_q    <= '0;
          mplier_q <= mgain_q;
          bit_q    <= '0;
          state_q  <= S_MUL;
        end
        S_MUL: begin
          // One gain bit per cycle, LSB first; multiplicand doubles each step.
          if (mplier_q[0])
            acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q <<< 1;
          mplier_q <= mplier_q >> 1;
          bit_q    <= bit_q + 3'd1;
          if (bit_q == 3'd7)
            state_q <= S_OUT;
        end
        S_OUT: begin
          audio_q <= audio_w;
          tick_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      pcnt_q  <= '0;
      dact_q  <= c_duty_mid;
      dpend_q <= c_duty_mid;
      pwm_q   <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_q + 1'b1;
      dpend_q <= dpend_d;
      pwm_q   <= (pcnt_q < dact_q);
      if (pcnt_q == {PWM_BITS{1'b1}})
        dact_q <= dpend_d;
    end
  end

  assign bus.audio_out  = audio_q;
  assign bus.audio_tick = tick_q;
  assign bus.gain_out   = gain_q;
  assign bus.overrun    = ovr_q;
  assign bus.pwm_out    = pwm_q;

endmodule
`default_nettype wire
